// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, types and level/pin helpers for the PWM generator
//
// Contents:
//   PWM_CNT_W   width of the shared PWM counter and of the duty value
//   NUM_CH      number of driven output pins
//   duty_t      8-bit duty type, 0x00 = 0 %, 0xFF = 100 %
//   pwm_cnt_t   PWM counter type
//   DUTY_FULL   duty code that forces a constant-high level
//   pwm_level() shared PWM level from counter and duty
//   pin_drive() per-pin force-low / static-high / PWM mux
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_CH    = 16;

    typedef logic [PWM_CNT_W-1:0] duty_t;
    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    localparam duty_t DUTY_FULL = 8'hFF;

    // A plain "cnt < duty" compare can never reach 100 % with an 8-bit
    // counter, so the all-ones duty code is special-cased to constant high.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input duty_t duty);
        logic lvl;
        if (duty == DUTY_FULL) begin
            lvl = 1'b1;
        end else begin
            lvl = (cnt < duty);
        end
        return lvl;
    endfunction

    // Disabled pins are low regardless of PWM mode; enabled pins are either
    // static high or follow the shared PWM level.
    function automatic logic [NUM_CH-1:0] pin_drive(
        input logic [NUM_CH-1:0] en_out,
        input logic [NUM_CH-1:0] en_pwm,
        input logic              level
    );
        return en_out & (~en_pwm | {NUM_CH{level}});
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - free-running clock divider producing the PWM counter tick
//
// Parameters:
//   CLK_DIV  clk cycles per tick, >= 1
//   DIV_W    prescaler counter width, derived from CLK_DIV
// Ports:
//   clk   input   system clock
//   rst   input   synchronous active-high reset
//   tick  output  high in the last cycle of every CLK_DIV-cycle interval
module pwm_prescaler #(
    parameter int CLK_DIV = 13,
    parameter int DIV_W   = $clog2(CLK_DIV) + 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    // Combinational tick so the PWM counter advances on the same edge the
    // prescaler wraps; with CLK_DIV == 1 the counter sits at 0 and ticks
    // every cycle.
    assign tick = (presc_q == DIV_LAST);

    always_comb begin
        presc_d = presc_q + DIV_W'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-pin PWM / static output driver fed by SPI control bytes
//
// Build option: define PWM_SYNC_UPDATE_EN to shadow the duty value and load it
// only at the period boundary; otherwise duty is used directly.
//
// Parameters:
//   CLK_DIV          clk cycles per PWM counter tick, >= 1
//   DIV_W            prescaler width, derived from CLK_DIV
// Ports:
//   clk              input   system clock
//   rst              input   synchronous active-high reset
//   en_reg_out_7_0   input   output enable, pins 7..0
//   en_reg_out_15_8  input   output enable, pins 15..8
//   en_reg_pwm_7_0   input   PWM-mode select, pins 7..0
//   en_reg_pwm_15_8  input   PWM-mode select, pins 15..8
//   pwm_duty_cycle   input   shared duty, 0x00 = 0 %, 0xFF = 100 %
//   pwm_out          output  registered pin drive
//   period_start     output  one-cycle pulse in the first cycle of a period
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13,
    parameter int DIV_W   = $clog2(CLK_DIV) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    logic              tick;
    logic              period_wrap;
    logic              level;
    duty_t             duty_active;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;

    pwm_cnt_t          pwm_cnt_q;
    pwm_cnt_t          pwm_cnt_d;
    logic              period_start_q;
    logic              period_start_d;
    logic [NUM_CH-1:0] pwm_out_q;
    logic [NUM_CH-1:0] pwm_out_d;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // The tick that moves the counter from all-ones back to zero marks the
    // period boundary; it drives both period_start and the duty shadow load.
    assign period_wrap = tick && (pwm_cnt_q == '1);

`ifdef PWM_SYNC_UPDATE_EN
    duty_t duty_active_q;
    duty_t duty_active_d;

    // Duty is only sampled at the boundary so a mid-period write can never
    // shorten or stretch the pulse already in progress.
    always_comb begin
        duty_active_d = duty_active_q;
        if (period_wrap) begin
            duty_active_d = duty_t'(pwm_duty_cycle);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active_q <= '0;
        end else begin
            duty_active_q <= duty_active_d;
        end
    end

    assign duty_active = duty_active_q;
`else
    assign duty_active = duty_t'(pwm_duty_cycle);
`endif

    assign level = pwm_level(pwm_cnt_q, duty_active);

    always_comb begin
        pwm_cnt_d      = pwm_cnt_q;
        period_start_d = period_wrap;
        pwm_out_d      = pin_drive(en_out, en_pwm, level);
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + pwm_cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
            pwm_out_q      <= '0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - self-checking bench for pwm_generator with CLK_DIV = 2
module tb_pwm_generator;

    localparam int DIV = 2;
    localparam int PER = 256 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty = 8'h80;
    logic [15:0] pwm_out;
    logic        period_start;

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_generator #(.CLK_DIV(DIV)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    // Reference model: m_t is the number of clock edges since the reset state,
    // so the counter value is simply (m_t / DIV) mod 256.
    int unsigned m_t = 0;
    logic [15:0] m_out = '0;
    logic        m_ps = 1'b0;
    logic [7:0]  m_shadow = '0;

    function automatic logic model_level(input int unsigned cnt, input logic [7:0] d);
        if (d == 8'hFF) return 1'b1;
        return (cnt < int'(d));
    endfunction

    function automatic logic [15:0] model_pins(input logic [15:0] eo, input logic [15:0] ep,
                                               input logic lvl);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else             r[i] = lvl;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_duty();
`ifdef PWM_SYNC_UPDATE_EN
        return m_shadow;
`else
        return duty;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t      <= 0;
            m_out    <= '0;
            m_ps     <= 1'b0;
            m_shadow <= '0;
        end else begin
            m_t   <= m_t + 1;
            m_out <= model_pins(en_out, en_pwm, model_level((m_t / DIV) % 256, model_duty()));
            m_ps  <= ((m_t % PER) == PER - 1);
            if ((m_t % PER) == PER - 1) m_shadow <= duty;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare both outputs to the model.
    task automatic step();
        @(negedge clk);
        checks++;
        assert (pwm_out === m_out) passes++;
        else begin
            fails++;
            $error("FAIL sb_pwm_out got=%h exp=%h t=%0d", pwm_out, m_out, m_t);
        end
        checks++;
        assert (period_start === m_ps) passes++;
        else begin
            fails++;
            $error("FAIL sb_period_start got=%b exp=%b t=%0d", period_start, m_ps, m_t);
        end
    endtask

    // Align to a period_start pulse, then count pwm_out[1] high cycles over
    // one full period; optionally rewrite duty at window offset chg_at.
    task automatic measure(input int chg_at, input logic [7:0] new_duty,
                           output int hi, output int first_hi);
        int n;
        n = 0;
        hi = 0;
        first_hi = -1;
        while (period_start !== 1'b1 && n < PER + 100) begin
            step();
            n++;
        end
        chk("measure_align", (n < PER + 100), 1);
        for (int k = 0; k < PER; k++) begin
            if (pwm_out[1] === 1'b1) begin
                hi++;
                if (first_hi < 0) first_hi = k;
            end
            if (k == chg_at) duty = new_duty;
            step();
        end
    endtask

    initial begin
        int hi, fh, first_ps, n;

        // Reset then idle.
        repeat (3) step();
        chk("reset_pwm_out", pwm_out, 0);
        chk("reset_period_start", period_start, 0);
        rst = 1'b0;
        first_ps = -1;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (period_start === 1'b1 && first_ps < 0) first_ps = k;
            if (pwm_out !== 16'h0000) chk("idle_pwm_out", pwm_out, 0);
        end
        chk("idle_first_period_start", first_ps, 512);

        // Static drive and enable clear.
        en_out = 16'h8001;
        en_pwm = 16'h0000;
        step();
        step();
        chk("static_8001", pwm_out, 16'h8001);
        en_out = 16'h0001;
        step();
        chk("static_bit15_clear", pwm_out[15], 0);
        chk("static_0001", pwm_out, 16'h0001);

        // Duty sweep on pin 1.
        en_out = 16'h0002;
        en_pwm = 16'h0002;
        duty = 8'h80;
        step();
        measure(-1, 8'h00, hi, fh);
        measure(-1, 8'h00, hi, fh);
        chk("duty80_high", hi, 256);
        chk("duty80_rise_offset", fh, 1);

        duty = 8'h00;
        step();
        measure(-1, 8'h00, hi, fh);
        measure(-1, 8'h00, hi, fh);
        chk("duty00_high", hi, 0);

        duty = 8'hFF;
        step();
        measure(-1, 8'h00, hi, fh);
        for (int p = 0; p < 3; p++) begin
            measure(-1, 8'h00, hi, fh);
            chk("dutyFF_high", hi, PER);
        end

        duty = 8'h01;
        step();
        measure(-1, 8'h00, hi, fh);
        measure(-1, 8'h00, hi, fh);
        chk("duty01_high", hi, 2);

        // Mid-period duty change at counter value 100 (window offset 200).
        duty = 8'h40;
        step();
        measure(-1, 8'h00, hi, fh);
        measure(200, 8'hC0, hi, fh);
`ifdef PWM_SYNC_UPDATE_EN
        chk("midchange_cur_period", hi, 128);
`else
        chk("midchange_cur_period", hi, 312);
`endif
        measure(-1, 8'h00, hi, fh);
        chk("midchange_next_period", hi, 384);

        // Randomized enables and duty, checked cycle by cycle against the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                en_out = 16'($urandom);
                en_pwm = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       duty = 8'h00;
                    1:       duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            step();
        end

        // Reset mid-period while the output is high.
        en_out = 16'h0002;
        en_pwm = 16'h0002;
        duty = 8'hFF;
        step();
        measure(-1, 8'h00, hi, fh);
        n = 0;
        while (((m_t / DIV) % 256) != 150 && n < PER + 100) begin
            step();
            n++;
        end
        chk("rst_align", (n < PER + 100), 1);
        chk("rst_pre_high", pwm_out[1], 1);
        rst = 1'b1;
        step();
        chk("rst_mid_pwm_out", pwm_out, 0);
        chk("rst_mid_period_start", period_start, 0);
        rst = 1'b0;
        n = 0;
        first_ps = -1;
        while (first_ps < 0 && n < PER + 100) begin
            step();
            n++;
            if (period_start === 1'b1) first_ps = n;
        end
        chk("rst_mid_first_period_start", first_ps, 512);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
